conv_sched: RTL and testbench

- Sequencer for the 16-filter 3x3 conv datapath. The datapath has a 3-row by 4-byte input shift register, a 16x3x3 weight store and 2 output columns per window.
- Fetches weights and then feature beats over a single in-order read port.
- Drives the datapath load strobes and flags each cycle in which a complete 3-row window is valid.
- Sits between the DMA/read fabric and the conv datapath; started by the host register block.

---
 rtl/conv_sched.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_conv_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// -----------------------------------------------------------------------------
// conv_sched -- sequencer for the 16-filter 3x3 convolution datapath.
//
// Fetches the weight block (36 beats), then the feature beats of every 4-column
// strip (strip-major, row-minor) over one in-order read port. It drives the
// weight-store write strobe and the datapath shift strobe in the return cycle,
// and raises a registered win_valid the cycle after every shift that completes
// a 3-row window.
//
// Optional feature: define CONV_SCHED_PERF_EN to add the 32-bit stall_cnt
// output (busy cycles with an ungranted request, saturating, cleared on start).
//
// Ports
//   clk, reset (async, active-low)
//   start, cfg_*            : host job launch and job configuration
//   rd_req/rd_addr/rd_gnt   : read request channel (held until granted)
//   rd_rvalid               : in-order read return
//   wgt_we/wgt_beat         : weight store write strobe and beat index
//   shift_en                : datapath shift strobe
//   win_valid/out_row/out_strip : window flag and its position
//   busy/done/err           : job status
// -----------------------------------------------------------------------------
module conv_sched #(
    parameter int ADDR_W    = 16,
    parameter int MAX_OUT   = 4,
    parameter int WGT_BEATS = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_wgt_base,
    input  logic [ADDR_W-1:0] cfg_feat_base,
    input  logic [7:0]        cfg_img_h,
    input  logic [7:0]        cfg_strips,
    input  logic              cfg_reuse_wgt,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_rvalid,
    output logic              wgt_we,
    output logic [5:0]        wgt_beat,
    output logic              shift_en,
    output logic              win_valid,
    output logic [7:0]        out_row,
    output logic [7:0]        out_strip,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WDRAIN,
        S_FEAT,
        S_FDRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
    logic [ADDR_W-1:0] feat_base_q, feat_base_d;
    logic [7:0]        img_h_q, img_h_d;
    logic [15:0]       total_q, total_d;      // feature beats in the job
    logic [15:0]       issue_q, issue_d;      // accepted requests this phase
    logic [3:0]        out_q, out_d;          // outstanding reads
    logic [5:0]        wret_q, wret_d;        // weight beats returned
    logic [7:0]        ret_row_q, ret_row_d;
    logic [7:0]        ret_strip_q, ret_strip_d;
    logic              win_valid_q, win_valid_d;
    logic [7:0]        out_row_q, out_row_d;
    logic [7:0]        out_strip_q, out_strip_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        start_ok;
    logic        cfg_bad;
    logic        active;
    logic        ret_ok;
    logic        req_c;
    logic        accept;
    logic        wgt_ret;
    logic        feat_ret;
    logic [15:0] phase_total;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        wgt_base_d   = wgt_base_q;
        feat_base_d  = feat_base_q;
        img_h_d      = img_h_q;
        total_d      = total_q;
        issue_d      = issue_q;
        out_d        = out_q;
        wret_d       = wret_q;
        ret_row_d    = ret_row_q;
        ret_strip_d  = ret_strip_q;
        win_valid_d  = 1'b0;
        out_row_d    = out_row_q;
        out_strip_d  = out_strip_q;
        err_d        = err_q;

        start_ok = start && (state_q == S_IDLE);
        cfg_bad  = (cfg_img_h < 8'd3) || (cfg_strips == 8'd0);
        active   = state_q inside {S_WLOAD, S_WDRAIN, S_FEAT, S_FDRAIN};
        // A return with nothing outstanding is a protocol violation: dropped.
        ret_ok   = rd_rvalid && active && (out_q != 4'd0);
        wgt_ret  = ret_ok && (state_q inside {S_WLOAD, S_WDRAIN});
        feat_ret = ret_ok && (state_q inside {S_FEAT, S_FDRAIN});

        phase_total = (state_q == S_WLOAD) ? 16'(WGT_BEATS) : total_q;
        // A same-cycle return frees a slot, so a full window may still issue.
        req_c  = (state_q inside {S_WLOAD, S_FEAT}) && (issue_q < phase_total) &&
                 ((out_q < 4'(MAX_OUT)) || rd_rvalid);
        accept = req_c && rd_gnt;

        if (accept) begin
            issue_d = issue_q + 16'd1;
        end
        if (accept && !ret_ok) begin
            out_d = out_q + 4'd1;
        end else if (!accept && ret_ok) begin
            out_d = out_q - 4'd1;
        end

        if (wgt_ret) begin
            wret_d = wret_q + 6'd1;
        end

        // Rows 0 and 1 of a strip only prime the shift register; the row
        // count alone gates validity, the slices themselves are never cleared.
        if (feat_ret) begin
            if (ret_row_q >= 8'd2) begin
                win_valid_d = 1'b1;
                out_row_d   = ret_row_q - 8'd2;
                out_strip_d = ret_strip_q;
            end
            if (ret_row_q == img_h_q - 8'd1) begin
                ret_row_d   = 8'd0;
                ret_strip_d = ret_strip_q + 8'd1;
            end else begin
                ret_row_d = ret_row_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    wgt_base_d  = cfg_wgt_base;
                    feat_base_d = cfg_feat_base;
                    img_h_d     = cfg_img_h;
                    total_d     = 16'(cfg_strips) * 16'(cfg_img_h);
                    issue_d     = 16'd0;
                    out_d       = 4'd0;
                    wret_d      = 6'd0;
                    ret_row_d   = 8'd0;
                    ret_strip_d = 8'd0;
                    err_d       = cfg_bad;
                    if (cfg_bad) begin
                        state_d = S_DONE;
                    end else if (cfg_reuse_wgt) begin
                        state_d = S_FEAT;
                    end else begin
                        state_d = S_WLOAD;
                    end
                end
            end
            S_WLOAD: begin
                if (accept && (issue_q == 16'(WGT_BEATS - 1))) begin
                    state_d = S_WDRAIN;
                end
            end
            S_WDRAIN: begin
                if (out_q == 4'd0) begin
                    issue_d = 16'd0;
                    state_d = S_FEAT;
                end
            end
            S_FEAT: begin
                if (accept && (issue_q == total_q - 16'd1)) begin
                    state_d = S_FDRAIN;
                end
            end
            S_FDRAIN: begin
                // With nothing outstanding the last return was in an earlier
                // cycle, so its win_valid is on the outputs now.
                if (out_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy covers the working states; it is already low in the done cycle.
        busy_d = !(state_d inside {S_IDLE, S_DONE});
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wgt_base_q  <= '0;
            feat_base_q <= '0;
            img_h_q     <= 8'd0;
            total_q     <= 16'd0;
            issue_q     <= 16'd0;
            out_q       <= 4'd0;
            wret_q      <= 6'd0;
            ret_row_q   <= 8'd0;
            ret_strip_q <= 8'd0;
            win_valid_q <= 1'b0;
            out_row_q   <= 8'd0;
            out_strip_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wgt_base_q  <= wgt_base_d;
            feat_base_q <= feat_base_d;
            img_h_q     <= img_h_d;
            total_q     <= total_d;
            issue_q     <= issue_d;
            out_q       <= out_d;
            wret_q      <= wret_d;
            ret_row_q   <= ret_row_d;
            ret_strip_q <= ret_strip_d;
            win_valid_q <= win_valid_d;
            out_row_q   <= out_row_d;
            out_strip_q <= out_strip_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = 32'd0;
        end else if (busy_q && req_c && !rd_gnt && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign rd_req    = req_c;
    assign rd_addr   = ((state_q == S_WLOAD) ? wgt_base_q : feat_base_q) + ADDR_W'(issue_q);
    assign wgt_we    = wgt_ret;
    assign wgt_beat  = wret_q;
    assign shift_en  = feat_ret;
    assign win_valid = win_valid_q;
    assign out_row   = out_row_q;
    assign out_strip = out_strip_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_sched.sv
`timescale 1ns/1ps
module tb_conv_sched;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] strip;
    } win_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_wgt_base = 16'h0;
    logic [15:0] cfg_feat_base = 16'h0;
    logic [7:0]  cfg_img_h = 8'h0;
    logic [7:0]  cfg_strips = 8'h0;
    logic        cfg_reuse_wgt = 1'b0;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_gnt;
    logic        rd_rvalid;
    logic        wgt_we;
    logic [5:0]  wgt_beat;
    logic        shift_en;
    logic        win_valid;
    logic [7:0]  out_row;
    logic [7:0]  out_strip;
    logic        busy;
    logic        done;
    logic        err;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_cnt;
`endif

    conv_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_wgt_base (cfg_wgt_base),
        .cfg_feat_base(cfg_feat_base),
        .cfg_img_h    (cfg_img_h),
        .cfg_strips   (cfg_strips),
        .cfg_reuse_wgt(cfg_reuse_wgt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_rvalid    (rd_rvalid),
        .wgt_we       (wgt_we),
        .wgt_beat     (wgt_beat),
        .shift_en     (shift_en),
        .win_valid    (win_valid),
        .out_row      (out_row),
        .out_strip    (out_strip),
        .busy         (busy),
        .done         (done),
        .err          (err)
`ifdef CONV_SCHED_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Scoreboards filled when a job is launched, drained by the fabric model.
    logic [15:0] exp_addr[$];
    logic [5:0]  exp_wgt[$];
    win_t        exp_win[$];
    int          due_q[$];      // return cycle of every accepted request

    int cyc          = 0;
    int lat_cfg      = 1;
    int gnt_off      = 0;       // ungranted request cycles still to impose
    bit gnt_rand     = 1'b0;
    int shift_seen   = 0;
    int rv_seen      = 0;
    int max_out_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Read fabric: grants, in-order returns after lat_cfg cycles, and
    // per-cycle protocol checks against the scoreboards.
    initial begin : fabric
        bit          rv;
        bit          pend;
        logic [15:0] pend_addr;
        win_t        w;
        rd_gnt    = 1'b1;
        rd_rvalid = 1'b0;
        pend      = 1'b0;
        pend_addr = 16'h0;
        forever begin
            @(negedge clk);
            cyc++;
            rv = (due_q.size() > 0) && (due_q[0] <= cyc);
            rd_rvalid = rv;
            #1;
            if (rd_req && gnt_off > 0) begin
                rd_gnt = 1'b0;
                gnt_off--;
            end else begin
                rd_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            if (rv) begin
                void'(due_q.pop_front());
                rv_seen++;
            end
            if (shift_en) shift_seen++;
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (exp_addr.size() == 0) check("idle_req", 32'(rd_req), 32'd0);
                if (pend) begin
                    check("req_hold", 32'(rd_req), 32'd1);
                    check("addr_hold", 32'(rd_addr), 32'(pend_addr));
                end
                pend      = rd_req && !rd_gnt;
                pend_addr = rd_addr;
                if (rd_req && rd_gnt) begin
                    due_q.push_back(cyc + lat_cfg);
                    if (exp_addr.size() > 0) check("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
                end
                if (due_q.size() > max_out_seen) max_out_seen = due_q.size();
                check("out_limit", 32'(due_q.size() > 4), 32'd0);

                check("wgt_we_rv", 32'(wgt_we && !rd_rvalid), 32'd0);
                if (exp_wgt.size() == 0) check("wgt_extra", 32'(wgt_we), 32'd0);
                else if (wgt_we) check("wgt_beat", 32'(wgt_beat), 32'(exp_wgt.pop_front()));

                check("shift_rv", 32'(shift_en && !rd_rvalid), 32'd0);

                if (exp_win.size() == 0) begin
                    check("win_extra", 32'(win_valid), 32'd0);
                end else if (win_valid) begin
                    w = exp_win.pop_front();
                    check("out_row", 32'(out_row), 32'(w.row));
                    check("out_strip", 32'(out_strip), 32'(w.strip));
                end
            end
        end
    end

    task automatic run_job(input logic [15:0] wb, input logic [15:0] fb,
                           input logic [7:0] h, input logic [7:0] s, input logic reuse,
                           input int lat, input int goff, input bit grand,
                           input bit bad, input int exp_stall);
        int n_feat;
        int shift0;
        int waited;
        n_feat = bad ? 0 : int'(h) * int'(s);
        if (!bad) begin
            if (!reuse) begin
                for (int i = 0; i < 36; i++) begin
                    exp_addr.push_back(wb + 16'(i));
                    exp_wgt.push_back(6'(i));
                end
            end
            for (int i = 0; i < n_feat; i++) exp_addr.push_back(fb + 16'(i));
            for (int st = 0; st < int'(s); st++)
                for (int r = 2; r < int'(h); r++)
                    exp_win.push_back('{row: 8'(r - 2), strip: 8'(st)});
        end
        lat_cfg      = lat;
        gnt_off      = goff;
        gnt_rand     = grand;
        max_out_seen = 0;
        shift0       = shift_seen;

        @(negedge clk);
        start         = 1'b1;
        cfg_wgt_base  = wb;
        cfg_feat_base = fb;
        cfg_img_h     = h;
        cfg_strips    = s;
        cfg_reuse_wgt = reuse;
        @(negedge clk);
        // Scramble the config: the running job must not see it.
        start         = 1'b0;
        cfg_wgt_base  = 16'hdead;
        cfg_feat_base = 16'hbeef;
        cfg_img_h     = 8'd1;
        cfg_strips    = 8'd0;
        cfg_reuse_wgt = ~reuse;
        #2;
        if (!bad) check("busy_on", 32'(busy), 32'd1);
        check("err_flag", 32'(err), 32'(bad));

        waited = 1;
        while (!done && waited < 4000) begin
            @(negedge clk);
            #2;
            waited++;
        end
        check("done_seen", 32'(done), 32'd1);
        if (bad) check("err_done_lat", 32'(waited <= 2), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("err_at_done", 32'(err), 32'(bad));
`ifdef CONV_SCHED_PERF_EN
        if (exp_stall >= 0) check("stall_cnt", stall_cnt, 32'(exp_stall));
`else
        if (exp_stall > 1000000) check("stall_arg", 32'(exp_stall), 32'd0);
`endif
        // A start offered in the done cycle must be dropped.
        start         = 1'b1;
        cfg_img_h     = 8'd4;
        cfg_strips    = 8'd1;
        cfg_reuse_wgt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("done_start_ign", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("err_after_ign", 32'(err), 32'(bad));
        repeat (3) @(negedge clk);
        #2;
        check("addr_left", 32'(exp_addr.size()), 32'd0);
        check("wgt_left", 32'(exp_wgt.size()), 32'd0);
        check("win_left", 32'(exp_win.size()), 32'd0);
        check("shift_cnt", 32'(shift_seen - shift0), 32'(n_feat));
        gnt_rand = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        int shift0;
        int rv0;

        // Reset state.
        repeat (3) @(negedge clk);
        #2;
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wgt_we", 32'(wgt_we), 32'd0);
        check("rst_wgt_beat", 32'(wgt_beat), 32'd0);
        check("rst_shift_en", 32'(shift_en), 32'd0);
        check("rst_win_valid", 32'(win_valid), 32'd0);
        check("rst_out_row", 32'(out_row), 32'd0);
        check("rst_out_strip", 32'(out_strip), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Weight load followed by a single-window strip.
        run_job(16'h0100, 16'h0200, 8'd3, 8'd1, 1'b0, 1, 0, 1'b0, 1'b0, -1);
        // Multi-strip with weight reuse.
        run_job(16'h0000, 16'h0040, 8'd5, 8'd2, 1'b1, 1, 0, 1'b0, 1'b0, -1);
        // Backpressure: 8 ungranted request cycles, 6-cycle returns.
        run_job(16'h0000, 16'h0040, 8'd5, 8'd2, 1'b1, 6, 8, 1'b0, 1'b0, -1);
        check("bp_max_out", 32'(max_out_seen), 32'd4);
        // Random grants, address wrap at the top of the space.
        run_job(16'hfff0, 16'hfffc, 8'd4, 8'd3, 1'b0, 3, 0, 1'b1, 1'b0, -1);
        // Config errors, then a valid start clears err.
        run_job(16'h0000, 16'h0040, 8'd2, 8'd1, 1'b0, 1, 0, 1'b0, 1'b1, -1);
        run_job(16'h0000, 16'h0040, 8'd4, 8'd0, 1'b1, 1, 0, 1'b0, 1'b1, -1);
        run_job(16'h0000, 16'h0080, 8'd3, 8'd1, 1'b1, 2, 0, 1'b0, 1'b0, -1);
`ifdef CONV_SCHED_PERF_EN
        run_job(16'h0000, 16'h0010, 8'd3, 8'd2, 1'b1, 1, 5, 1'b0, 1'b0, 5);
`endif

        // Reset mid-FEAT with 3 reads outstanding.
        for (int i = 0; i < 10; i++) exp_addr.push_back(16'h0300 + 16'(i));
        lat_cfg  = 30;
        gnt_off  = 0;
        gnt_rand = 1'b0;
        @(negedge clk);
        start         = 1'b1;
        cfg_feat_base = 16'h0300;
        cfg_img_h     = 8'd5;
        cfg_strips    = 8'd2;
        cfg_reuse_wgt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (due_q.size() != 3 && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("rst_out3", 32'(due_q.size()), 32'd3);
        reset = 1'b0;
        exp_addr.delete();
        exp_wgt.delete();
        exp_win.delete();
        shift0 = shift_seen;
        rv0    = rv_seen;
        repeat (3) @(negedge clk);
        #2;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req", 32'(rd_req), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        k = 0;
        while (due_q.size() != 0 && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        @(negedge clk);
        #2;
        check("post_rst_rv", 32'(rv_seen - rv0), 32'd3);
        check("post_rst_shift", 32'(shift_seen - shift0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_win", 32'(win_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
